// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int ZERO_IDX  = 0;

   // Address width for a register count; never narrower than one bit.
   function automatic int rf_aw(input int nregs);
      return (nregs <= 2) ? 1 : $clog2(nregs);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bits for every register: the issue set has the highest priority,
// then the flush, then the writeback clear. Looks up NRD read addresses plus the issue address.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int AW       = rf_aw(NREGS_DEF),
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [AW-1:0]         i_wa,
   input  logic                  i_clr,
   input  logic                  i_ie,
   input  logic [AW-1:0]         i_ia,
   input  logic [(NRD+1)*AW-1:0] i_addr,
   output logic [NRD:0]          o_pend
);

   logic [NREGS-1:0] r_pend;
   logic [NREGS-1:0] w_pend_nxt;

   always_comb begin
      w_pend_nxt = r_pend;
      if (i_we)  w_pend_nxt[i_wa] = 1'b0;
      if (i_clr) w_pend_nxt = '0;
      if (i_ie)  w_pend_nxt[i_ia] = 1'b1;
      // The hardwired zero register can never have an outstanding producer.
      if (ZERO_REG != 0) w_pend_nxt[ZERO_IDX] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_pend <= '0;
      else          r_pend <= w_pend_nxt;
   end

   for (genvar g = 0; g <= NRD; g++) begin : g_rdout
      assign o_pend[g] = r_pend[i_addr[g*AW +: AW]];
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with pending-write scoreboard and optional
// same-cycle writeback forwarding to every read port.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int   XLEN     = XLEN_DEF,
   parameter int   NREGS    = NREGS_DEF,
   parameter int   NRD      = 2,
   parameter int   ZERO_REG = 1,
   parameter int   BYPASS   = 1,
   localparam int  AW       = rf_aw(NREGS)
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [NRD*AW-1:0]   RA,
   output logic [NRD*XLEN-1:0] RD,
   output logic [NRD-1:0]      RBUSY,
   input  logic                WE,
   input  logic [AW-1:0]       WA,
   input  logic [XLEN-1:0]     WD,
   input  logic                IE,
   input  logic [AW-1:0]       IA,
   output logic                IBUSY,
   input  logic                CLR
);

   logic [XLEN-1:0] r_mem [NREGS];
   logic            w_wr_ok;
   logic            w_ia_ok;
   logic [NRD:0]    w_pend;

   assign w_wr_ok = WE && !((ZERO_REG != 0) && (WA == AW'(ZERO_IDX)));
   assign w_ia_ok = IE && !((ZERO_REG != 0) && (IA == AW'(ZERO_IDX)));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int k = 0; k < NREGS; k++) r_mem[k] <= '0;
      end else if (w_wr_ok) begin
         r_mem[WA] <= WD;
      end
   end

   rf_scoreboard #(
      .NREGS    (NREGS),
      .AW       (AW),
      .NRD      (NRD),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_we    (WE),
      .i_wa    (WA),
      .i_clr   (CLR),
      .i_ie    (w_ia_ok),
      .i_ia    (IA),
      .i_addr  ({IA, RA}),
      .o_pend  (w_pend)
   );

   assign IBUSY = w_pend[NRD];

   for (genvar i = 0; i < NRD; i++) begin : g_rport
      logic [AW-1:0] w_ra;
      logic          w_hit;
      logic          w_zero;

      assign w_ra   = RA[i*AW +: AW];
      assign w_zero = (ZERO_REG != 0) && (w_ra == AW'(ZERO_IDX));
      assign w_hit  = (BYPASS != 0) && w_wr_ok && (WA == w_ra);

      assign RD[i*XLEN +: XLEN] = w_zero ? '0 : (w_hit ? WD : r_mem[w_ra]);
      // A forwarded value is the completed result, so it no longer counts as outstanding.
      assign RBUSY[i] = w_pend[i] && !w_hit;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed vector bench for reg_file_mp (default configuration) plus a
// randomised model-based sweep of a 4-port, 16x64, no-bypass configuration.
module tb_reg_file_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // Instance A: XLEN=32, NREGS=32, NRD=2, ZERO_REG=1, BYPASS=1
   logic [9:0]  a_ra;
   logic [63:0] a_rd;
   logic [1:0]  a_rbusy;
   logic        a_we, a_ie, a_clr, a_ibusy;
   logic [4:0]  a_wa, a_ia;
   logic [31:0] a_wd;

   // Instance B: XLEN=64, NREGS=16, NRD=4, ZERO_REG=1, BYPASS=0
   logic [15:0]  b_ra;
   logic [255:0] b_rd;
   logic [3:0]   b_rbusy;
   logic         b_we, b_ie, b_clr, b_ibusy;
   logic [3:0]   b_wa, b_ia;
   logic [63:0]  b_wd;

   reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
      .CLK(clk), .RST_N(rst_n), .RA(a_ra), .RD(a_rd), .RBUSY(a_rbusy),
      .WE(a_we), .WA(a_wa), .WD(a_wd), .IE(a_ie), .IA(a_ia),
      .IBUSY(a_ibusy), .CLR(a_clr));

   reg_file_mp #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
      .CLK(clk), .RST_N(rst_n), .RA(b_ra), .RD(b_rd), .RBUSY(b_rbusy),
      .WE(b_we), .WA(b_wa), .WD(b_wd), .IE(b_ie), .IA(b_ia),
      .IBUSY(b_ibusy), .CLR(b_clr));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ie;
      logic [4:0]  ia;
      logic        clr;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic        rb0;
      logic        rb1;
      logic        ib;
   } vec_t;

   localparam int NV = 18;
   vec_t vt[NV];

   function automatic vec_t mv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic ie, input logic [4:0] ia, input logic clr,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic [31:0] rd0, input logic [31:0] rd1,
                               input logic rb0, input logic rb1, input logic ib);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.clr = clr;
      v.ra0 = ra0; v.ra1 = ra1; v.rd0 = rd0; v.rd1 = rd1;
      v.rb0 = rb0; v.rb1 = rb1; v.ib = ib;
      return v;
   endfunction

   // Sweep reference model
   logic [63:0] m_mem  [16];
   logic        m_pend [16];

   initial begin
      //          we wa  wd            ie ia  clr ra0 ra1 rd0           rd1           rb0 rb1 ib
      vt[0]  = mv(0, 0,  32'h0,        0, 0,  0,  0,  5,  32'h0,        32'h0,        0,  0,  0);
      vt[1]  = mv(1, 7,  32'h12345678, 0, 0,  0,  7,  7,  32'h12345678, 32'h12345678, 0,  0,  0);
      vt[2]  = mv(0, 0,  32'h0,        0, 0,  0,  7,  0,  32'h12345678, 32'h0,        0,  0,  0);
      vt[3]  = mv(0, 0,  32'h0,        1, 3,  0,  3,  0,  32'h0,        32'h0,        0,  0,  0);
      vt[4]  = mv(0, 0,  32'h0,        0, 3,  0,  3,  3,  32'h0,        32'h0,        1,  1,  1);
      vt[5]  = mv(1, 3,  32'hAAAA5555, 0, 3,  0,  3,  3,  32'hAAAA5555, 32'hAAAA5555, 0,  0,  1);
      vt[6]  = mv(0, 0,  32'h0,        0, 3,  0,  3,  7,  32'hAAAA5555, 32'h12345678, 0,  0,  0);
      vt[7]  = mv(1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  0,  32'h0,        32'h0,        0,  0,  0);
      vt[8]  = mv(0, 0,  32'h0,        0, 0,  0,  0,  3,  32'h0,        32'hAAAA5555, 0,  0,  0);
      vt[9]  = mv(1, 9,  32'h99999999, 1, 9,  0,  9,  0,  32'h99999999, 32'h0,        0,  0,  0);
      vt[10] = mv(0, 0,  32'h0,        0, 9,  0,  9,  9,  32'h99999999, 32'h99999999, 1,  1,  1);
      vt[11] = mv(0, 0,  32'h0,        1, 12, 0,  12, 9,  32'h0,        32'h99999999, 0,  1,  0);
      vt[12] = mv(0, 0,  32'h0,        1, 4,  1,  9,  12, 32'h99999999, 32'h0,        1,  1,  0);
      vt[13] = mv(0, 0,  32'h0,        0, 4,  0,  9,  12, 32'h99999999, 32'h0,        0,  0,  1);
      vt[14] = mv(1, 4,  32'h44444444, 0, 4,  1,  4,  12, 32'h44444444, 32'h0,        0,  0,  1);
      vt[15] = mv(0, 0,  32'h0,        0, 4,  0,  4,  4,  32'h44444444, 32'h44444444, 0,  0,  0);
      vt[16] = mv(1, 20, 32'h20202020, 0, 20, 0,  20, 20, 32'h20202020, 32'h20202020, 0,  0,  0);
      vt[17] = mv(0, 0,  32'h0,        0, 20, 0,  20, 20, 32'h20202020, 32'h20202020, 0,  0,  0);

      rst_n = 1'b0;
      a_ra = '0; a_we = 0; a_wa = '0; a_wd = '0; a_ie = 0; a_ia = '0; a_clr = 0;
      b_ra = '0; b_we = 0; b_wa = '0; b_wd = '0; b_ie = 0; b_ia = '0; b_clr = 0;
      #1;
      chk("reset_rd", a_rd, 64'h0);
      chk("reset_rbusy", {62'h0, a_rbusy}, 64'h0);
      chk("reset_ibusy", {63'h0, a_ibusy}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < NV; v++) begin
         @(negedge clk);
         a_we = vt[v].we; a_wa = vt[v].wa; a_wd = vt[v].wd;
         a_ie = vt[v].ie; a_ia = vt[v].ia; a_clr = vt[v].clr;
         a_ra = {vt[v].ra1, vt[v].ra0};
         #1;
         chk($sformatf("v%0d_rd0", v), {32'h0, a_rd[31:0]},  {32'h0, vt[v].rd0});
         chk($sformatf("v%0d_rd1", v), {32'h0, a_rd[63:32]}, {32'h0, vt[v].rd1});
         chk($sformatf("v%0d_rbusy0", v), {63'h0, a_rbusy[0]}, {63'h0, vt[v].rb0});
         chk($sformatf("v%0d_rbusy1", v), {63'h0, a_rbusy[1]}, {63'h0, vt[v].rb1});
         chk($sformatf("v%0d_ibusy", v), {63'h0, a_ibusy}, {63'h0, vt[v].ib});
      end

      // Reset asserted mid-run, between clock edges
      @(negedge clk);
      a_we = 1; a_wa = 5; a_wd = 32'hDEADBEEF; a_ie = 1; a_ia = 6; a_clr = 0;
      @(negedge clk);
      a_we = 0; a_ie = 0; a_ra = {5'd6, 5'd5}; a_ia = 6;
      #1;
      chk("pre_rst_rd5", {32'h0, a_rd[31:0]}, 64'hDEADBEEF);
      chk("pre_rst_rbusy6", {63'h0, a_rbusy[1]}, 64'h1);
      chk("pre_rst_ibusy6", {63'h0, a_ibusy}, 64'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rd5", {32'h0, a_rd[31:0]}, 64'h0);
      chk("mid_rst_rbusy6", {63'h0, a_rbusy[1]}, 64'h0);
      chk("mid_rst_ibusy6", {63'h0, a_ibusy}, 64'h0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_rd5", {32'h0, a_rd[31:0]}, 64'h0);
      chk("post_rst_rbusy6", {63'h0, a_rbusy[1]}, 64'h0);

      // Randomised sweep of the no-bypass configuration against a reference model
      for (int r = 0; r < 16; r++) begin
         m_mem[r]  = '0;
         m_pend[r] = 1'b0;
      end
      for (int c = 0; c < 300; c++) begin
         logic [3:0] ra [4];
         @(negedge clk);
         b_we  = ($urandom_range(0, 1) == 1);
         b_wa  = 4'($urandom_range(0, 15));
         b_wd  = {$urandom, $urandom};
         b_ie  = ($urandom_range(0, 2) == 0);
         b_ia  = 4'($urandom_range(0, 15));
         b_clr = ($urandom_range(0, 15) == 0);
         for (int p = 0; p < 4; p++) ra[p] = 4'($urandom_range(0, 15));
         // Frequently read the register being written to expose any forwarding.
         if ($urandom_range(0, 2) == 0) ra[0] = b_wa;
         b_ra = {ra[3], ra[2], ra[1], ra[0]};
         #1;
         for (int p = 0; p < 4; p++) begin
            chk($sformatf("sw%0d_rd%0d", c, p), b_rd[p*64 +: 64],
                (ra[p] == 4'd0) ? 64'h0 : m_mem[ra[p]]);
            chk($sformatf("sw%0d_rbusy%0d", c, p), {63'h0, b_rbusy[p]}, {63'h0, m_pend[ra[p]]});
         end
         chk($sformatf("sw%0d_ibusy", c), {63'h0, b_ibusy}, {63'h0, m_pend[b_ia]});
         if (b_we && b_wa != 4'd0) m_mem[b_wa] = b_wd;
         if (b_we) m_pend[b_wa] = 1'b0;
         if (b_clr) for (int r = 0; r < 16; r++) m_pend[r] = 1'b0;
         if (b_ie && b_ia != 4'd0) m_pend[b_ia] = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file with an integrated pending-write scoreboard and same-cycle write bypass. Next-generation replacement for the 32x32 two-read/one-write register file in the RISC-V datapath. Sits between decode (read, issue) and writeback. Lets the pipeline detect RAW/WAW hazards without an external scoreboard.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers (power of two, ≥2); AW = $clog2(NREGS)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- RA  in  NRD*AW  read addresses, port i in bits [i*AW +: AW]
- RD  out  NRD*XLEN  read data, port i in bits [i*XLEN +: XLEN]
- RBUSY  out  NRD  1 = register addressed by port i has a write outstanding
- WE  in  1  writeback enable
- WA  in  AW  writeback address
- WD  in  XLEN  writeback data
- IE  in  1  issue enable: mark IA as pending
- IA  in  AW  issue destination address
- IBUSY  out  1  pending state of IA (WAW check), combinational
- CLR  in  1  flush: clear all pending bits (pipeline squash)

## Operation
- Storage: NREGS x XLEN array plus NREGS pending bits.
- Reset (RST_N low, any time): all registers = 0, all pending = 0, effective immediately. RD then reads 0, RBUSY = 0, IBUSY = 0.
- Write: on rising edge, if WE and not (ZERO_REG and WA==0), reg[WA] <= WD.
- Read (combinational, per port i): if BYPASS and WE and WA==RA_i and write legal -> RD_i = WD; else RD_i = reg[RA_i]. ZERO_REG and RA_i==0 -> RD_i = 0 always.
- RBUSY_i = pending[RA_i] and not bypass hit on port i; 0 for register 0 when ZERO_REG. BYPASS=0: RBUSY_i = pending[RA_i].
- IBUSY = pending[IA] (0 for register 0 when ZERO_REG).
- Pending update per edge, in priority order, low to high:
  - WE clears pending[WA].
  - CLR clears all pending.
  - IE sets pending[IA], unless IA==0 with ZERO_REG.
  - The highest-priority action wins for a given register.
- Same-address WE and IE in one cycle: register written, pending stays 1 (new producer).
- CLR with WE same cycle: write still occurs, pending cleared.
- Writes to a non-pending register are legal: data written, pending unchanged at 0.
- Multiple read ports with the same address return identical data and busy.

## Timing
- Read latency 0 (combinational from RA, WA, WE, WD, pending).
- Write latency 1: data visible without bypass on the cycle after the WE edge.
- Pending set or clear visible on RBUSY/IBUSY the cycle after the edge.
- No combinational path from IE/IA/CLR to RD.
- Reset deassertion is used synchronously by the surrounding design; the block requires no recovery cycles.

## Structure
- Shared package rf_pkg:
  - XLEN_DEF = 32, NREGS_DEF = 32, ZERO_IDX = 0.
  - Function for AW derivation.
- Sub-module rf_scoreboard: NREGS pending bits with set/clear/flush priority logic, read-out muxes for NRD+1 addresses.
- Top reg_file_mp contains the data array, write logic, and per-port bypass muxes, generated over NRD.

## Test plan
- Reset mid-run: write 0xDEADBEEF to x5, assert RST_N low between edges -> RD for x5 = 0 immediately, RBUSY = 0.
- Zero register: WE with WA=0, WD=0xFFFFFFFF; IE with IA=0 -> RD(x0) = 0 always, RBUSY/IBUSY for x0 = 0.
- Bypass: WE, WA=7, WD=0x12345678, RA0=7 in the same cycle -> RD0 = 0x12345678, RBUSY0 = 0 that cycle; RD0 unchanged on the next cycle with WE low.
- Scoreboard: IE IA=3 at cycle n -> RBUSY for RA=3 is 1 from n+1; WE WA=3 at cycle m -> RBUSY = 0 from m+1; IBUSY tracks the same.
- Simultaneous events: WE and IE to x9 same cycle -> x9 written, pending stays 1. CLR with IE IA=4 -> all pending 0 except x4.
- Parameter sweep: NRD=4, NREGS=16, XLEN=64, BYPASS=0 -> random write/read compare against reference model, no bypass forwarding observed.
